mtr_duty_sched: RTL
===================

Name: mtr_duty_sched

Overview:
- Duty-cycle scheduler and over-current supervisor for the two 11-bit PWM generators that drive the left and right motors.
- Converts signed speed commands into mid-scale-offset duties and applies them only at period boundaries (PWM_synch).
- Slew-limits each duty per PWM period.
- Counts unblanked over-current periods and latches a fault that forces both motors to zero torque until a timed, acknowledged recovery.

Parameters:
- MAX_SPD, 11'd959, magnitude clip on speed; keeps duty within [0x041, 0x7BF] so duty+NONOVERLAP never wraps.
- SLEW, 11'd32, maximum duty change per PWM period.
- OVR_LIMIT, 4'd8, net bad-period count that trips the fault.
- HOLD_PERIODS, 8'd200, minimum PWM periods spent in FAULT before clr_fault is honoured.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- lft_spd  in  11  signed left speed command
- rght_spd  in  11  signed right speed command
- PWM_synch  in  1  one-cycle pulse at PWM count 0 (shared by both PWM generators)
- ovr_I_blank  in  1  high while current sense is invalid
- OVR_I_lft  in  1  raw left over-current comparator
- OVR_I_rght  in  1  raw right over-current comparator
- clr_fault  in  1  fault acknowledge, level
- lft_duty  out  11  duty to left PWM generator
- rght_duty  out  11  duty to right PWM generator
- fault  out  1  fault latched
- ocp_cnt  out  4  current bad-period count, for debug

Behaviour:
- Reset values: lft_duty = rght_duty = 11'h400; fault = 0; ocp_cnt = 0; state = RUN; per-period flag = 0; hold counter = 0.
- Target computation (combinational):
  - clip spd to [-MAX_SPD, +MAX_SPD] with signed compare.
  - target = 11'h400 + clipped spd, computed at 12 bits.
  - Result is always in range, so truncation to 11 bits is lossless.
- Duty update happens only in the cycle PWM_synch = 1; the registered duty is visible the next clk. Each side is independent:
  - |target - duty| <= SLEW: duty <= target.
  - Otherwise duty moves SLEW toward target.
  - No update in any other cycle, even if the speed command changes.
- Over-current sampling:
  - Per-period flag sets on any cycle with ovr_I_blank = 0 and (OVR_I_lft | OVR_I_rght).
  - Samples taken while ovr_I_blank = 1 are ignored.
- Period evaluation, on each PWM_synch:
  - bad = flag OR a qualifying sample in this same cycle.
  - Flag clears (a sample in the synch cycle counts for the closing period only).
  - bad: ocp_cnt increments, saturating at OVR_LIMIT. Clean: ocp_cnt decrements, saturating at 0.
- States:
  - RUN:
    - normal slewing.
    - if the evaluation makes ocp_cnt reach OVR_LIMIT, go to FAULT in the next clk.
    - on entry to FAULT: fault = 1, both duties = 11'h400 immediately (not slewed), hold counter = 0.
  - FAULT:
    - duties held at 11'h400; OCP sampling is suspended.
    - hold counter increments per PWM_synch, saturating at HOLD_PERIODS.
    - when hold = HOLD_PERIODS and clr_fault = 1, go to RECOVER: fault = 0, ocp_cnt = 0, flag = 0.
    - clr_fault is ignored before the hold expires; it must still be high after expiry to be honoured.
  - RECOVER:
    - same slewing and OCP rules as RUN, starting from 11'h400.
    - go to RUN at the first PWM_synch after which both duties equal their targets.
    - if ocp_cnt reaches OVR_LIMIT in RECOVER, go to FAULT exactly as from RUN.
- Simultaneous events:
  - Trip and a command change in the same synch cycle: trip wins, duties = 11'h400.
  - clr_fault while in RUN or RECOVER: no effect.
- Reset mid-operation: all registers return to reset values asynchronously; fault clears; duties return to mid-scale.

Decomposition:
- Shared package `mtr_pkg`:
  - state enum (RUN, FAULT, RECOVER).
  - DUTY_MID = 11'h400.
  - NONOVERLAP = 11'h040, which MAX_SPD is derived against.
- Sub-module `duty_slew`, instantiated twice (left, right):
  - clip, offset and slew for one side.
  - inputs: clk, rst_n, spd, synch, force_mid.
  - outputs: duty, at_target.
- The top level holds the OCP counter, flag, hold counter and FSM.

Test Plan:
- Reset, lft_spd = 0, rght_spd = 0, periodic synch: both duties = 0x400, fault = 0.
- lft_spd = +200 at duty 0x400:
  - duty follows 0x420, 0x440, ..., one step per synch, settling at 0x4C8 after 7 synchs (0x4C0 then 0x4C8).
  - no change between synchs.
- rght_spd = -1024: clips to -959, target 0x041; rght_spd = +1023: target 0x7BF.
- OVR_I_lft pulsed only while ovr_I_blank = 1 for 20 periods: ocp_cnt stays 0.
- OVR_I_lft unblanked in 8 consecutive periods:
  - fault = 1 one clk after the 8th synch, duties = 0x400.
  - clr_fault held from period 10 to 199: no exit; at hold = 200 the state goes to RECOVER and duties re-ramp by 32 per period.
- Alternating bad and clean periods: ocp_cnt oscillates 1/0 and never trips; rst_n asserted while fault = 1 gives fault = 0 and duties = 0x400 asynchronously.

Source files
------------

// File: rtl/mtr_duty_sched_pkg.sv
// Shared definitions for the motor duty scheduler.
// Holds the supervisor state encoding and the duty-scale constants
// that the speed clip is derived against.
package mtr_pkg;

  // Supervisor states.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } mtr_state_e;

  // Zero-torque duty (mid-scale of the 11-bit PWM).
  localparam logic [10:0] DUTY_MID   = 11'h400;
  // Dead time added by the PWM generator; duty + NONOVERLAP must never wrap.
  localparam logic [10:0] NONOVERLAP = 11'h040;

endpackage

// File: rtl/mtr_duty_sched_if.sv
// Command/status bundle between the motor controller and mtr_duty_sched.
//   lft_spd, rght_spd           signed 11-bit speed commands
//   PWM_synch                   one-cycle pulse at PWM count 0
//   ovr_I_blank                 current sense invalid
//   OVR_I_lft, OVR_I_rght       raw over-current comparators
//   clr_fault                   fault acknowledge (level)
//   lft_duty, rght_duty         duties to the PWM generators
//   fault, ocp_cnt              latched fault, bad-period count (debug)
// master: the controller side; slave: the scheduler.
interface mtr_duty_sched_if;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        PWM_synch;
  logic        ovr_I_blank;
  logic        OVR_I_lft;
  logic        OVR_I_rght;
  logic        clr_fault;
  logic [10:0] lft_duty;
  logic [10:0] rght_duty;
  logic        fault;
  logic [3:0]  ocp_cnt;

  modport master (
    output lft_spd, rght_spd, PWM_synch, ovr_I_blank,
           OVR_I_lft, OVR_I_rght, clr_fault,
    input  lft_duty, rght_duty, fault, ocp_cnt
  );

  modport slave (
    input  lft_spd, rght_spd, PWM_synch, ovr_I_blank,
           OVR_I_lft, OVR_I_rght, clr_fault,
    output lft_duty, rght_duty, fault, ocp_cnt
  );
endinterface

// File: rtl/mtr_duty_sched_duty_slew.sv
// One motor side: clip the signed speed, offset it to mid-scale and
// slew the registered duty toward it once per PWM period.
//   clk, rst_n   clock, async active-low reset
//   spd          signed speed command
//   synch        PWM period boundary; the only cycle the duty may move
//   force_mid    load mid-scale immediately (fault entry / fault hold)
//   duty         registered duty
//   at_target    the value duty would take at this synch equals the target
module duty_slew
  import mtr_pkg::*;
#(
  parameter logic [10:0] MAX_SPD = 11'd959,
  parameter logic [10:0] SLEW    = 11'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] spd,
  input  logic        synch,
  input  logic        force_mid,
  output logic [10:0] duty,
  output logic        at_target
);

  logic signed [10:0] spd_s;
  logic signed [10:0] max_s;
  logic signed [10:0] min_s;
  logic signed [10:0] clip;
  logic        [11:0] target_w;
  logic signed [11:0] diff;
  logic signed [11:0] slew_s;
  logic        [10:0] duty_nxt;

  assign spd_s = $signed(spd);
  assign max_s = $signed(MAX_SPD);
  assign min_s = -max_s;

  always_comb begin
    clip = spd_s;
    if (spd_s > max_s)
      clip = max_s;
    else if (spd_s < min_s)
      clip = min_s;
  end

  // The clipped sum always lies in [0x041, 0x7BF], so bit 11 is never set
  // and the 12-bit value doubles as a non-negative signed operand below.
  assign target_w = {1'b0, DUTY_MID} + {clip[10], clip};
  assign diff     = $signed(target_w) - $signed({1'b0, duty});
  assign slew_s   = $signed({1'b0, SLEW});

  always_comb begin
    duty_nxt = target_w[10:0];
    if (diff > slew_s)
      duty_nxt = duty + SLEW;
    else if (diff < -slew_s)
      duty_nxt = duty - SLEW;
  end

  assign at_target = (duty_nxt == target_w[10:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      duty <= DUTY_MID;
    else if (force_mid)
      duty <= DUTY_MID;
    else if (synch)
      duty <= duty_nxt;
  end

endmodule

// File: rtl/mtr_duty_sched.sv
// Duty scheduler and over-current supervisor for the left/right motor PWMs.
// Speed commands become slew-limited duties applied at PWM period
// boundaries; unblanked over-current periods are counted and a latched
// fault holds both motors at zero torque until a timed acknowledge.
//   clk, rst_n   clock, async active-low reset
//   bus          mtr_duty_sched_if.slave (commands in, duties/status out)
//
// state    | meaning
// RUN      | normal slewing, OCP counting
// FAULT    | duties pinned at mid-scale, OCP ignored, hold timer running
// RECOVER  | slewing back from mid-scale; RUN once both sides settle
module mtr_duty_sched
  import mtr_pkg::*;
#(
  parameter logic [10:0] MAX_SPD      = DUTY_MID - NONOVERLAP - 11'd1,
  parameter logic [10:0] SLEW         = 11'd32,
  parameter logic [3:0]  OVR_LIMIT    = 4'd8,
  parameter logic [7:0]  HOLD_PERIODS = 8'd200
) (
  input  logic            clk,
  input  logic            rst_n,
  mtr_duty_sched_if.slave bus
);

  localparam logic [1:0] RUN     = ST_RUN;
  localparam logic [1:0] FAULT   = ST_FAULT;
  localparam logic [1:0] RECOVER = ST_RECOVER;

  logic [1:0]  state;
  logic        ovr_flag;
  logic [3:0]  ocp_cnt;
  logic [3:0]  ocp_nxt;
  logic [7:0]  hold_cnt;
  logic        fault;
  logic        in_fault;
  logic        sample_ok;
  logic        bad;
  logic        trip;
  logic        force_mid;
  logic [10:0] lft_duty;
  logic [10:0] rght_duty;
  logic        lft_at;
  logic        rght_at;

  assign in_fault  = (state == FAULT);
  assign sample_ok = !in_fault && !bus.ovr_I_blank &&
                     (bus.OVR_I_lft || bus.OVR_I_rght);
  // A hit in the synch cycle itself belongs to the period being closed.
  assign bad       = ovr_flag || sample_ok;

  always_comb begin
    ocp_nxt = ocp_cnt;
    if (bad) begin
      if (ocp_cnt < OVR_LIMIT)
        ocp_nxt = ocp_cnt + 4'd1;
    end else if (ocp_cnt != 4'd0) begin
      ocp_nxt = ocp_cnt - 4'd1;
    end
  end

  // Trip overrides any slew step taken in the same synch cycle.
  assign trip      = bus.PWM_synch && !in_fault && (ocp_nxt == OVR_LIMIT);
  assign force_mid = trip || in_fault;

  duty_slew #(.MAX_SPD(MAX_SPD), .SLEW(SLEW)) u_lft (
    .clk       (clk),
    .rst_n     (rst_n),
    .spd       (bus.lft_spd),
    .synch     (bus.PWM_synch),
    .force_mid (force_mid),
    .duty      (lft_duty),
    .at_target (lft_at)
  );

  duty_slew #(.MAX_SPD(MAX_SPD), .SLEW(SLEW)) u_rght (
    .clk       (clk),
    .rst_n     (rst_n),
    .spd       (bus.rght_spd),
    .synch     (bus.PWM_synch),
    .force_mid (force_mid),
    .duty      (rght_duty),
    .at_target (rght_at)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      ovr_flag <= 1'b0;
      ocp_cnt  <= 4'd0;
      hold_cnt <= 8'd0;
      fault    <= 1'b0;
    end else begin
      case (state)
        FAULT: begin
          if (bus.PWM_synch && (hold_cnt != HOLD_PERIODS))
            hold_cnt <= hold_cnt + 8'd1;
          // Acknowledge only counts once the hold has already expired.
          if ((hold_cnt == HOLD_PERIODS) && bus.clr_fault) begin
            state    <= RECOVER;
            fault    <= 1'b0;
            ocp_cnt  <= 4'd0;
            ovr_flag <= 1'b0;
          end
        end
        default: begin
          if (bus.PWM_synch) begin
            ovr_flag <= 1'b0;
            ocp_cnt  <= ocp_nxt;
            if (trip) begin
              state    <= FAULT;
              fault    <= 1'b1;
              hold_cnt <= 8'd0;
            end else if ((state != RUN) && lft_at && rght_at) begin
              state <= RUN;
            end
          end else if (sample_ok) begin
            ovr_flag <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.lft_duty  = lft_duty;
  assign bus.rght_duty = rght_duty;
  assign bus.fault     = fault;
  assign bus.ocp_cnt   = ocp_cnt;

endmodule
